// File: rtl/button_encoder.sv
// button_encoder: synchronizes and debounces four 3-bit button sources and
// serializes new-press events into a round-robin Select/ButtonVector stream.
module button_encoder #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [2:0] ButtonsIn1,
  input  logic [2:0] ButtonsIn2,
  input  logic [2:0] ButtonsIn3,
  input  logic [2:0] ButtonsIn4,
  input  logic       Ready,
  output logic       Valid,
  output logic [2:0] Select,
  output logic [2:0] ButtonVector
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    ST_IDLE,
    ST_PRESENT
  } state_t;

  logic [3:0][2:0]       raw_in;
  logic [3:0][2:0]       sync1_q;
  logic [3:0][2:0]       sync2_q;
  logic [3:0][2:0]       deb_q;
  logic [3:0][2:0]       deb_d;
  logic [3:0][CNT_W-1:0] cnt_q;
  logic [3:0][CNT_W-1:0] cnt_d;
  logic [3:0]            press;
  logic [3:0]            pending_q;
  logic [3:0]            pending_d;
  logic [3:0][2:0]       pend_vec_q;
  logic [3:0][2:0]       pend_vec_d;
  logic [1:0]            last_q;
  logic [1:0]            last_d;
  state_t                state_q;
  state_t                state_d;
  logic                  valid_q;
  logic                  valid_d;
  logic [2:0]            select_q;
  logic [2:0]            select_d;
  logic [2:0]            vector_q;
  logic [2:0]            vector_d;
  logic                  grant_found;
  logic [1:0]            grant_idx;
  logic [1:0]            cand;

  assign raw_in[0] = ButtonsIn1;
  assign raw_in[1] = ButtonsIn2;
  assign raw_in[2] = ButtonsIn3;
  assign raw_in[3] = ButtonsIn4;

  // A new value arriving in sync2 (sync1 differs) restarts the count, but a
  // value already stable for the full window is accepted first.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    press = '0;
    for (int i = 0; i < 4; i++) begin
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          deb_d[i] = sync2_q[i];
          press[i] = |(sync2_q[i] & ~deb_q[i]);
        end else if (sync1_q[i] != sync2_q[i]) begin
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_q + 2'(k);
      if (!grant_found && pending_q[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    pending_d  = pending_q;
    pend_vec_d = pend_vec_q;
    last_d     = last_q;
    state_d    = state_q;
    valid_d    = valid_q;
    select_d   = select_q;
    vector_d   = vector_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_found) begin
          state_d               = ST_PRESENT;
          valid_d               = 1'b1;
          select_d              = 3'(grant_idx) + 3'd1;
          vector_d              = pend_vec_q[grant_idx];
          pending_d[grant_idx]  = 1'b0;
          pend_vec_d[grant_idx] = '0;
          last_d                = grant_idx;
        end
      end
      ST_PRESENT: begin
        if (Ready) begin
          state_d  = ST_IDLE;
          valid_d  = 1'b0;
          select_d = '0;
          vector_d = '0;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        valid_d  = 1'b0;
        select_d = '0;
        vector_d = '0;
      end
    endcase
    // Applied after the grant so a same-edge press on the granted source survives.
    for (int i = 0; i < 4; i++) begin
      if (press[i]) begin
        pending_d[i]  = 1'b1;
        pend_vec_d[i] = pend_vec_d[i] | deb_d[i];
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      cnt_q      <= '0;
      pending_q  <= '0;
      pend_vec_q <= '0;
      last_q     <= 2'd3;
      state_q    <= ST_IDLE;
      valid_q    <= 1'b0;
      select_q   <= '0;
      vector_q   <= '0;
    end else begin
      sync1_q    <= raw_in;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      cnt_q      <= cnt_d;
      pending_q  <= pending_d;
      pend_vec_q <= pend_vec_d;
      last_q     <= last_d;
      state_q    <= state_d;
      valid_q    <= valid_d;
      select_q   <= select_d;
      vector_q   <= vector_d;
    end
  end

  assign Valid        = valid_q;
  assign Select       = select_q;
  assign ButtonVector = vector_q;

endmodule

// File: doc/button_encoder.md
# button_encoder

Collects raw 3-bit button vectors from four player/input sources, synchronizes and debounces each, and serializes new-press events into one Select + ButtonVector stream with a Valid/Ready handshake. It is the upstream counterpart of the button decoder. Select uses the same code space: 1..4 = source, 0 = none. Arbitration between sources is round-robin, so no source can starve another.

## Interface
- DEBOUNCE_CYCLES, 4: consecutive stable cycles required before a debounced bit changes; range 2..255.
- Clock  input  1  sole clock, rising edge.
- Reset  input  1  asynchronous, active-high; clears all state.
- ButtonsIn1  input  3  raw active-high buttons, source 1 (asynchronous to Clock).
- ButtonsIn2  input  3  raw buttons, source 2.
- ButtonsIn3  input  3  raw buttons, source 3.
- ButtonsIn4  input  3  raw buttons, source 4.
- Ready  input  1  consumer accepts the current event.
- Valid  output  1  Select/ButtonVector hold an event.
- Select  output  3  source index 1..4; 0 when Valid=0.
- ButtonVector  output  3  debounced button state of the selected source at press time; 0 when Valid=0.

## Operation
- **Sync:** each of the 12 raw bits passes through a 2-flop synchronizer.
- **Debounce:** each source has a debounced register Deb[i] and a counter of width clog2(DEBOUNCE_CYCLES).
  - If Sync2[i] equals Deb[i], the counter clears.
  - Otherwise the counter increments. On the edge where the counter is DEBOUNCE_CYCLES-1 and Sync2 still differs, Deb[i] takes Sync2[i] and the counter clears.
  - All three bits of a source share one counter. Any change of the 3-bit value restarts the count.
- **Press event:** on the edge where Deb[i] updates with at least one 0->1 bit, Pending[i] is set and PendVec[i] takes PendVec[i] OR the new Deb[i].
  - Release-only updates produce no event.
- **FSM states:**
  - IDLE: Valid=0, Select=0, ButtonVector=0. If any Pending bit is set, grant the first pending source searching from Last+1 and wrapping 4->1.
  - On a grant: load Select=i and ButtonVector=PendVec[i], clear Pending[i] and PendVec[i], set Last=i, go to PRESENT.
  - PRESENT: Valid=1. Outputs are stable while Ready=0. When Ready=1, go to IDLE and drop Valid/Select/ButtonVector to 0 on that edge.
- **Simultaneous grant and new press, same source, same edge:** the new press wins. Pending[i] stays set and PendVec[i] holds only the new Deb[i], so no event is lost.
- **Presses during PRESENT:** they accumulate in Pending/PendVec. Repeat presses of one source merge by OR into one event.
- **Reset values** (immediately on Reset assertion, regardless of Clock):
  - Sync, Deb, counters, Pending and PendVec all 0.
  - Last=4, so the first search order is 1,2,3,4.
  - FSM=IDLE.
  - Valid=0, Select=0, ButtonVector=0.
- **Reset mid-PRESENT:** the event in flight and all pending events are discarded.
  - Buttons held through reset are seen as new presses once debounced after reset.

## Timing
- All outputs are registered; there are no combinational paths from Ready or ButtonsIn to any output.
- **Press latency:** with a raw change stable before edge 1:
  - Sync2 changes at edge 2.
  - Deb and Pending update at edge 2+DEBOUNCE_CYCLES.
  - Valid rises after edge 3+DEBOUNCE_CYCLES, which is edge 7 at the default setting.
- **Debounce rejection:** a glitch lasting at most DEBOUNCE_CYCLES-1 cycles after synchronization never changes Deb.
- **Handshake:** the transfer occurs on an edge with Valid=1 and Ready=1.
  - Valid is then 0 for at least one cycle (IDLE) before the next grant.
  - Maximum throughput is one event per 2 cycles.
- Ready is ignored while Valid=0.

## Test plan
- **Reset:** assert Reset with all inputs toggling -> Valid=0, Select=0 and ButtonVector=0 throughout. After release, no event while inputs stay 0.
- **Single press:** ButtonsIn2=3'b101 held, Ready=1 -> Valid rises exactly 7 cycles after the first sampling edge with Select=2 and ButtonVector=3'b101. Valid falls the next cycle; no further event while the button is held or when it is released.
- **Glitch:** ButtonsIn3=3'b010 for 3 cycles, then 0 -> no Valid ever. A 5-cycle pulse -> exactly one event with Select=3 and ButtonVector=3'b010.
- **Arbitration:** after reset, ButtonsIn1=3'b001 and ButtonsIn3=3'b100 assert on the same edge, Ready=1:
  - Events come out in the order Select=1, then Select=3, separated by one Valid=0 cycle.
  - Then press 1 and 3 again with Last=3 -> order is 1 then 3; with Last=1 -> order is 3 then 1.
- **Backpressure and merge:** hold Ready=0 while Valid=1 (Select=4, ButtonVector=3'b001).
  - Press source 4 with 3'b010, release it, then press 3'b100.
  - Outputs stay unchanged until Ready=1. The next event is Select=4 with ButtonVector=3'b110.
- **Reset mid-operation:** Valid=1 and one pending event, then assert Reset for 1 cycle -> outputs go to 0 asynchronously and no event follows unless a button is re-pressed.
